// File: rtl/dfm_pkg.sv
// Shared types and widths for the measurement datapath (measure -> result FIFO -> software).
package dfm_pkg;

  localparam int DFM_DATA_WIDTH = 64;
  localparam int DFM_BUS_WIDTH  = 32;

  typedef enum logic {HALF_LO, HALF_HI} half_t;

  typedef logic [DFM_DATA_WIDTH-1:0] dfm_result_t;

endpackage

// File: rtl/result_mem.sv
// Result storage: DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read.
module result_mem
  import dfm_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = DFM_DATA_WIDTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; entries are only read after being written, and
  // leaving it out keeps this a plain register file instead of DEPTH*DATA_WIDTH reset flops.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/result_fifo.sv
// Buffers 64-bit measurement results and serves them to software as two 32-bit reads
// (low word first; the high-word read pops the entry). Tracks level and sticky overflow.
module result_fifo
  import dfm_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = DFM_DATA_WIDTH,
  parameter int BUS_WIDTH  = DFM_BUS_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  input  logic                    clr_i,
  output logic [BUS_WIDTH-1:0]    rd_data_o,
  output logic                    rd_valid_o,
  output logic                    rd_half_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  half_t                 half_q, half_d;
  logic                  rd_accept, pop, wr_accept, ovf_set;
  logic                  is_empty, is_full;
  logic [DATA_WIDTH-1:0] mem_rdata;

  result_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rdata)
  );

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LW'(DEPTH));

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    half_d    = half_q;
    rd_accept = 1'b0;
    pop       = 1'b0;
    wr_accept = 1'b0;
    ovf_set   = 1'b0;
    level_d   = level_q;
    if (clr_i) begin
      half_d = HALF_LO;
    end else begin
      // Emptiness is judged on the pre-edge level, so a write landing this cycle
      // cannot be read until the next one.
      rd_accept = rd_en_i && !is_empty;
      pop       = rd_accept && (half_q == HALF_HI);
      wr_accept = wr_en_i && (!is_full || pop);
      ovf_set   = wr_en_i && is_full && !pop;
      if (rd_accept) begin
        half_d = (half_q == HALF_LO) ? HALF_HI : HALF_LO;
      end
      level_d = level_q + LW'(wr_accept) - LW'(pop);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q <= HALF_LO;
    end else begin
      half_q <= half_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      ovf_o      <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else if (clr_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      ovf_o      <= 1'b0;
      rd_valid_o <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + AW'(1);
      if (ovf_set)   ovf_o    <= 1'b1;
      level_q    <= level_d;
      empty_o    <= (level_d == '0);
      full_o     <= (level_d == LW'(DEPTH));
      rd_valid_o <= rd_accept;
      if (rd_accept) begin
        rd_data_o <= (half_q == HALF_LO) ? mem_rdata[BUS_WIDTH-1:0]
                                         : mem_rdata[DATA_WIDTH-1:BUS_WIDTH];
      end
    end
  end

  assign level_o   = level_q;
  assign rd_half_o = (half_q == HALF_HI);

endmodule
